divisor_tick_gen: RTL
=====================

# divisor_tick_gen

Multi-channel, runtime-programmable clock-enable generator.
- Produces, per channel, a single-cycle `tick_out` strobe every D cycles and an optional 50 % duty `wave_out` with period 2·D.
- All outputs are synchronous to `Clock`; no derived clocks.
- Feeds the alarm-control timing logic: blink rates, debounce sampling and second/minute timebases.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent channels (1..16).
- `CNT_W`, 26: divisor and counter width in bits.
- `DEFAULT_DIV`, 25_000_000: divisor loaded into every channel at reset (1 Hz wave at 50 MHz).

Ports:
- `Clock`: input, 1. Single system clock; all logic on its rising edge.
- `Reset_n`: input, 1. Asynchronous, active-low reset.
- `ch_en`: input, NUM_CH. Per-channel run enable.
- `sync_clr`: input, 1. Restarts all channels phase-aligned.
- `cfg_we`: input, 1. Divisor write strobe.
- `cfg_ch`: input, $clog2(NUM_CH) (min 1). Target channel; values ≥ NUM_CH are ignored.
- `cfg_div`: input, CNT_W. New divisor D.
- `tick_out`: output, NUM_CH. Registered one-cycle strobe per channel.
- `wave_out`: output, NUM_CH. Registered square wave per channel.

## Operation
Each channel holds three registers: `div_shadow`, `div_active` and a down-counter `cnt`.

- **Reset (async):**
  - `div_shadow` = `div_active` = DEFAULT_DIV.
  - `cnt` = DEFAULT_DIV−1.
  - `tick_out` = 0, `wave_out` = 0.
- **Divisor 0:** D = 0 is treated as D = 1 (tick every cycle). Applies to writes and to DEFAULT_DIV.
- **Config write:**
  - `cfg_we` high captures `cfg_div` into `div_shadow[cfg_ch]` on the clock edge.
  - `div_active` takes `div_shadow` only at a reload event, so there are no mid-period glitches.
- **Reload event:** terminal count (`cnt`==0 while enabled), `sync_clr`, or the channel being disabled.
  - Sets `div_active` ← `div_shadow`.
  - Sets `cnt` ← effective `div_shadow` − 1.
- **Running** (`ch_en` high, `sync_clr` low):
  - If `cnt` ≠ 0: `cnt` decrements and `tick_out` = 0 on the next edge.
  - If `cnt` == 0: reload, `tick_out` = 1 for exactly one cycle, and `wave_out` toggles.
- **Disabled** (`ch_en` low): reload every cycle, `tick_out` = 0, `wave_out` = 0.
- **`sync_clr`:** overrides running state in all channels. Reload, `tick_out` = 0, `wave_out` = 0.
- **Simultaneous events:**
  - A write on the same edge as a terminal count does not affect that reload; it applies at the following reload.
  - A write on the same edge as `sync_clr` is captured, and that reload uses the old shadow.
  - Priority per channel: Reset_n > sync_clr > ~ch_en > terminal count > decrement.
- **Wrap-around:** `cnt` never underflows; 0 always reloads.

## Timing
- **Enable-to-tick latency:** `ch_en` rises before edge 0 (same edge as reload). `tick_out` is then high after edges D, 2D, 3D, … and low otherwise.
- **Wave:** `wave_out` toggles on the same edges as `tick_out`. Period 2·D, duty exactly 50 %.
- **Write latency:**
  - Written on edge k, the divisor takes effect at the first reload after edge k.
  - At most one old period completes.
- **`sync_clr`:**
  - Asserted for edge s; the first tick of every enabled channel follows at edge s+D_ch.
  - Channels with equal D remain phase-locked.
- **Reset release:**
  - No glitch; outputs remain 0 until the first terminal count.
  - Reset_n assertion mid-period clears outputs immediately, without waiting for an edge.

## Configuration
Macro `DIVISOR_TICK_WAVE_EN`:
- **Defined:** `wave_out` toggle flops are built as described above.
- **Undefined:** `wave_out` is tied to all-zero and the toggle flops are removed. `tick_out` behaviour is unchanged.

## Structure
- Package `divisor_tick_pkg` holds:
  - `MAX_CH` = 16.
  - Function `eff_div(d)`, the 0→1 mapping.
  - Localparam for the default divisor width.
- Sub-module `divisor_tick_channel` holds one channel's shadow, active, counter, tick and wave logic. The top instantiates it with a generate loop and decodes `cfg_we`/`cfg_ch` into per-channel write strobes.

## Test plan
Bench parameters: NUM_CH=4, CNT_W=8, DEFAULT_DIV=5.
- **Reset/enable:** release Reset_n, hold ch_en=4'b0001 from edge 0.
  - `tick_out[0]` is high after edges 5, 10, 15.
  - `wave_out[0]` is 0→1 at 5 and 1→0 at 10.
  - Other channels stay 0.
- **Glitch-free write:** ch 1 running D=5; write cfg_div=3 at edge 2 of a period.
  - Ticks at 5, 8, 11 relative to that period start.
- **Divisor 0 / same-edge write:**
  - Write D=0 to ch 2: `tick_out[2]` is high every cycle, and `wave_out[2]` toggles every cycle.
  - A write coinciding with a terminal count applies one period later.
- **`sync_clr` alignment:** ch 0 D=5, ch 3 D=5, started 2 cycles apart.
  - Pulse sync_clr at edge s.
  - Both tick at s+5, s+10.
  - Waves read 0 after s.
- **Disable/reset mid-period:** deassert ch_en at cnt=2; `tick_out` and `wave_out` are 0 next edge, and re-enable restarts a full D.
  - Assert Reset_n low mid-period: outputs 0 asynchronously.
  - After release, D returns to 5.
- **Macro off:** build without DIVISOR_TICK_WAVE_EN. `wave_out` is constantly 0 and ticks are identical to the first scenario.

Source files
------------

// File: rtl/divisor_tick_pkg.sv
// divisor_tick_pkg: shared limits and divisor helpers for the tick generator.
package divisor_tick_pkg;
   localparam int unsigned MAX_CH = 16;
   localparam int unsigned DIV_W  = 32;
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction
endpackage

// File: rtl/divisor_tick_channel.sv
// divisor_tick_channel: one channel's shadow/active divisor, down-counter, tick and wave.
// The wave toggle flop exists only when DIVISOR_TICK_WAVE_EN is defined.
module divisor_tick_channel import divisor_tick_pkg::*; #(
   parameter int unsigned       CNT_W       = 26,
   parameter logic [CNT_W-1:0]  DEFAULT_DIV = CNT_W'(25_000_000)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             we_i,
   input  logic [CNT_W-1:0] div_i,
   output logic             tick_o,
   output logic             wave_o
);
   localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(eff_div(DIV_W'(DEFAULT_DIV)) - 1);
   logic [CNT_W-1:0] shadow_q, shadow_d, active_q, active_d, cnt_q, cnt_d, rld;
   logic             tick_q, tick_d, tc, reload, cnt_ok;
   always_comb begin
      tc       = en_i && !clr_i && (cnt_q == '0);
      reload   = clr_i || !en_i || (cnt_q == '0);
      rld      = CNT_W'(eff_div(DIV_W'(shadow_q)) - 1);
      shadow_d = we_i ? div_i : shadow_q;
      active_d = reload ? shadow_q : active_q;
      cnt_d    = reload ? rld : cnt_q - CNT_W'(1);
      tick_d   = tc;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shadow_q <= DEFAULT_DIV;
         active_q <= DEFAULT_DIV;
         cnt_q    <= RST_CNT;
         tick_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         tick_q   <= tick_d;
      end
   end
   assign tick_o = tick_q;
   // The counter always stays inside the period of the divisor it was loaded from.
   assign cnt_ok = DIV_W'(cnt_q) < eff_div(DIV_W'(active_q));
   a_cnt_in_period: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_ok);
`ifdef DIVISOR_TICK_WAVE_EN
   logic wave_q, wave_d;
   assign wave_d = (clr_i || !en_i) ? 1'b0 : wave_q ^ tc;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) wave_q <= 1'b0;
      else         wave_q <= wave_d;
   end
   assign wave_o = wave_q;
`else
   assign wave_o = 1'b0;
`endif
endmodule

// File: rtl/divisor_tick_gen.sv
// divisor_tick_gen: multi-channel programmable clock-enable (tick/wave) generator.
// Define DIVISOR_TICK_WAVE_EN to build the 50 % duty wave outputs; otherwise wave_out is 0.
module divisor_tick_gen import divisor_tick_pkg::*; #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 26,
   parameter int unsigned DEFAULT_DIV = 25_000_000,
   localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_clr,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] wave_out
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Out-of-range cfg_ch values match no channel and are dropped.
      divisor_tick_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
      ) u_ch (
         .clk_i  (Clock),
         .rst_ni (Reset_n),
         .en_i   (ch_en[i]),
         .clr_i  (sync_clr),
         .we_i   (cfg_we && (cfg_ch == CH_W'(i))),
         .div_i  (cfg_div),
         .tick_o (tick_out[i]),
         .wave_o (wave_out[i])
      );
   end
endmodule
